// File: rtl/hood_key_power_ctrl.sv
// Range-hood front end: button sync/debounce, key pulses, power on/off FSM
// with long-press power-off, and the 1 Hz timebase for the mode FSM.
module hood_key_power_ctrl #(
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int TICK_CYC     = 100000000,
  parameter int LONG_PRESS_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn_raw,
  input  logic       menu_btn_raw,
  input  logic       level1_btn_raw,
  input  logic       level2_btn_raw,
  input  logic       level3_btn_raw,
  output logic       is_on,
  output logic       menu_key,
  output logic       level1_key,
  output logic       level2_key,
  output logic       level3_key,
  output logic       slow_clk,
  output logic       sec_tick,
  output logic [2:0] hold_sec
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int TK_W = $clog2(TICK_CYC + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TK_W-1:0] TK_MAX  = TK_W'(TICK_CYC - 1);
  localparam logic [TK_W-1:0] TK_HALF = TK_W'(TICK_CYC / 2);
  localparam logic [2:0]      LP_SEC  = 3'(LONG_PRESS_S);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON_WAIT_REL,
    S_ON,
    S_OFF_HOLD,
    S_OFF_WAIT_REL
  } state_t;

  state_t state, state_n;

  logic [4:0]      raw;
  logic [4:0]      sync_p0, sync_p1;
  logic [4:0]      db_lvl, db_lvl_d;
  logic [DB_W-1:0] db_cnt [5];
  logic [4:0]      edge_c;
  logic            pw, pe, keys_on;
  logic [TK_W-1:0] tb_cnt, tb_cnt_n;
  logic [TK_W-1:0] hold_cnt, hold_cnt_n;
  logic [2:0]      hold_sec_n;
  logic            sec_done;

  // Saturating seconds counter; the FSM leaves OFF_HOLD at LP_SEC anyway.
  function automatic logic [2:0] sec_inc(input logic [2:0] s);
    return (s >= LP_SEC) ? LP_SEC : s + 3'd1;
  endfunction

  // Bit order: 0 power, 1 menu, 2 level1, 3 level2, 4 level3.
  assign raw = {level3_btn_raw, level2_btn_raw, level1_btn_raw, menu_btn_raw, power_btn_raw};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_lvl[i] <= ~db_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign edge_c = db_lvl & ~db_lvl_d;
  assign pw     = db_lvl[0];
  assign pe     = edge_c[0];

  assign tb_cnt_n = (tb_cnt == TK_MAX) ? '0 : tb_cnt + 1'b1;
  assign sec_done = (hold_cnt == TK_MAX);

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    hold_sec_n = '0;
    case (state)
      S_OFF:         if (pe) state_n = S_ON_WAIT_REL;
      S_ON_WAIT_REL: if (!pw) state_n = S_ON;
      S_ON: begin
        if (pe) begin
          state_n    = S_OFF_HOLD;
          hold_cnt_n = '0;
        end
      end
      S_OFF_HOLD: begin
        hold_sec_n = hold_sec;
        if (sec_done) begin
          hold_cnt_n = '0;
          hold_sec_n = sec_inc(hold_sec);
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
        // Completing the final second beats a release in the same cycle.
        if (hold_sec_n == LP_SEC) begin
          state_n = S_OFF_WAIT_REL;
        end else if (!pw) begin
          state_n    = S_ON;
          hold_sec_n = '0;
          hold_cnt_n = '0;
        end
      end
      S_OFF_WAIT_REL: if (!pw) state_n = S_OFF;
      default:        state_n = S_OFF;
    endcase
  end

  assign keys_on = (state_n == S_ON) || (state_n == S_OFF_HOLD);

  // Stage p2: registered FSM state, outputs and timebase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_OFF;
      hold_cnt   <= '0;
      hold_sec   <= '0;
      tb_cnt     <= '0;
      is_on      <= 1'b0;
      menu_key   <= 1'b0;
      level1_key <= 1'b0;
      level2_key <= 1'b0;
      level3_key <= 1'b0;
      slow_clk   <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      hold_sec   <= hold_sec_n;
      tb_cnt     <= tb_cnt_n;
      is_on      <= (state_n == S_ON_WAIT_REL) || (state_n == S_ON) || (state_n == S_OFF_HOLD);
      menu_key   <= keys_on & edge_c[1];
      level1_key <= keys_on & edge_c[2] & ~edge_c[1];
      level2_key <= keys_on & edge_c[3] & ~edge_c[2] & ~edge_c[1];
      level3_key <= keys_on & edge_c[4] & ~edge_c[3] & ~edge_c[2] & ~edge_c[1];
      slow_clk   <= (tb_cnt_n >= TK_HALF);
      sec_tick   <= (tb_cnt == TK_MAX);
    end
  end

endmodule

// File: tb/tb_hood_key_power_ctrl.sv
// Scoreboard bench for hood_key_power_ctrl: per-cycle expectations are queued
// when stimulus is applied and compared on the falling edge of their cycle.
module tb_hood_key_power_ctrl;

  localparam int DB = 4;
  localparam int TK = 10;
  localparam int LP = 3;

  localparam int SIG_ON = 0, SIG_MENU = 1, SIG_L1 = 2, SIG_L2 = 3, SIG_L3 = 4;
  localparam int SIG_SLOW = 5, SIG_TICK = 6, SIG_HOLD = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwr = 1'b0, menu = 1'b0, l1 = 1'b0, l2 = 1'b0, l3 = 1'b0;
  logic       is_on, menu_key, level1_key, level2_key, level3_key;
  logic       slow_clk, sec_tick;
  logic [2:0] hold_sec;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];

  hood_key_power_ctrl #(
    .DEBOUNCE_CYC(DB),
    .TICK_CYC(TK),
    .LONG_PRESS_S(LP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power_btn_raw(pwr),
    .menu_btn_raw(menu),
    .level1_btn_raw(l1),
    .level2_btn_raw(l2),
    .level3_btn_raw(l3),
    .is_on(is_on),
    .menu_key(menu_key),
    .level1_key(level1_key),
    .level2_key(level2_key),
    .level3_key(level3_key),
    .slow_clk(slow_clk),
    .sec_tick(sec_tick),
    .hold_sec(hold_sec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] obs(input int sig);
    case (sig)
      SIG_ON:   return {3'b0, is_on};
      SIG_MENU: return {3'b0, menu_key};
      SIG_L1:   return {3'b0, level1_key};
      SIG_L2:   return {3'b0, level2_key};
      SIG_L3:   return {3'b0, level3_key};
      SIG_SLOW: return {3'b0, slow_clk};
      SIG_TICK: return {3'b0, sec_tick};
      default:  return {1'b0, hold_sec};
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      SIG_ON:   return "is_on";
      SIG_MENU: return "menu_key";
      SIG_L1:   return "level1_key";
      SIG_L2:   return "level2_key";
      SIG_L3:   return "level3_key";
      SIG_SLOW: return "slow_clk";
      SIG_TICK: return "sec_tick";
      default:  return "hold_sec";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_rng(input int sig, input int from, input int to, input logic [3:0] v);
    for (int k = from; k <= to; k++) sb.push_back('{k, sig, v});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string when);
    chk({when, ".is_on"},    {3'b0, is_on},      4'd0);
    chk({when, ".hold_sec"}, {1'b0, hold_sec},   4'd0);
    chk({when, ".slow_clk"}, {3'b0, slow_clk},   4'd0);
    chk({when, ".sec_tick"}, {3'b0, sec_tick},   4'd0);
    chk({when, ".keys"},     {menu_key, level1_key, level2_key, level3_key}, 4'd0);
  endtask

  // Timebase restarts at 0 on reset release; the first edge brings it to 1.
  task automatic expect_timebase(input int r, input int n);
    for (int k = 1; k <= n; k++) begin
      expect_rng(SIG_SLOW, r + k, r + k, 4'((k % TK) >= TK / 2));
      expect_rng(SIG_TICK, r + k, r + k, 4'((k % TK) == 0));
    end
  endtask

  // Compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("%s@%0d", sname(sb[i].sig), cyc), obs(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;

    wait_cyc(2);
    chk_all_zero("reset");

    // Idle after reset: timebase only
    rst = 1'b1;
    r = cyc;
    expect_timebase(r, 25);
    expect_rng(SIG_ON,   r + 1, r + 25, 4'd0);
    expect_rng(SIG_HOLD, r + 1, r + 25, 4'd0);
    expect_rng(SIG_MENU, r + 1, r + 25, 4'd0);
    expect_rng(SIG_L1,   r + 1, r + 25, 4'd0);
    wait_cyc(25);

    // Short glitch on power is rejected
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_ON, c + 1, c + 15, 4'd0);
    wait_cyc(3);
    pwr = 1'b0;
    wait_cyc(12);

    // Real press powers on after 7 cycles; the held press never starts power-off
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_ON,   c + 1, c + 6,  4'd0);
    expect_rng(SIG_ON,   c + 7, c + 64, 4'd1);
    expect_rng(SIG_HOLD, c + 1, c + 64, 4'd0);
    wait_cyc(50);
    pwr = 1'b0;
    wait_cyc(15);

    // Simultaneous menu + level2: menu wins, level2 dropped, no release pulse
    c = cyc;
    menu = 1'b1;
    l2 = 1'b1;
    expect_rng(SIG_MENU, c + 1, c + 6,  4'd0);
    expect_rng(SIG_MENU, c + 7, c + 7,  4'd1);
    expect_rng(SIG_MENU, c + 8, c + 25, 4'd0);
    expect_rng(SIG_L2,   c + 1, c + 25, 4'd0);
    expect_rng(SIG_L1,   c + 1, c + 25, 4'd0);
    expect_rng(SIG_L3,   c + 1, c + 25, 4'd0);
    wait_cyc(8);
    menu = 1'b0;
    l2 = 1'b0;
    wait_cyc(20);

    // Long press: hold_sec 1,2,3 then power off; level1 gated while off
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_HOLD, c + 1,  c + 16, 4'd0);
    expect_rng(SIG_HOLD, c + 17, c + 26, 4'd1);
    expect_rng(SIG_HOLD, c + 27, c + 36, 4'd2);
    expect_rng(SIG_HOLD, c + 37, c + 37, 4'd3);
    expect_rng(SIG_HOLD, c + 38, c + 70, 4'd0);
    expect_rng(SIG_ON,   c + 1,  c + 36, 4'd1);
    expect_rng(SIG_ON,   c + 37, c + 70, 4'd0);
    wait_cyc(38);
    l1 = 1'b1;
    expect_rng(SIG_L1, c + 39, c + 60, 4'd0);
    wait_cyc(7);
    pwr = 1'b0;
    wait_cyc(1);
    l1 = 1'b0;
    wait_cyc(24);

    // Power on again
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_ON, c + 1, c + 6,  4'd0);
    expect_rng(SIG_ON, c + 7, c + 24, 4'd1);
    wait_cyc(10);
    pwr = 1'b0;
    wait_cyc(15);

    // Aborted long press: hold_sec reaches 2 then clears; level3 still works
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_HOLD, c + 1,  c + 16, 4'd0);
    expect_rng(SIG_HOLD, c + 17, c + 26, 4'd1);
    expect_rng(SIG_HOLD, c + 27, c + 31, 4'd2);
    expect_rng(SIG_HOLD, c + 32, c + 60, 4'd0);
    expect_rng(SIG_ON,   c + 1,  c + 60, 4'd1);
    wait_cyc(25);
    pwr = 1'b0;
    wait_cyc(15);
    l3 = 1'b1;
    expect_rng(SIG_L3,   c + 41, c + 46, 4'd0);
    expect_rng(SIG_L3,   c + 47, c + 47, 4'd1);
    expect_rng(SIG_L3,   c + 48, c + 60, 4'd0);
    expect_rng(SIG_MENU, c + 41, c + 60, 4'd0);
    wait_cyc(8);
    l3 = 1'b0;
    wait_cyc(15);

    // Reset asserted in the middle of OFF_HOLD
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_ON,   c + 7,  c + 21, 4'd1);
    expect_rng(SIG_HOLD, c + 17, c + 21, 4'd1);
    wait_cyc(22);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    pwr = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    r = cyc;
    expect_timebase(r, 12);
    expect_rng(SIG_ON,   r + 1, r + 20, 4'd0);
    expect_rng(SIG_HOLD, r + 1, r + 20, 4'd0);
    wait_cyc(20);

    // Fresh press needed after reset
    c = cyc;
    pwr = 1'b1;
    expect_rng(SIG_ON, c + 1, c + 6,  4'd0);
    expect_rng(SIG_ON, c + 7, c + 12, 4'd1);
    wait_cyc(10);
    pwr = 1'b0;
    wait_cyc(10);

    chk("sb_drained", (sb.size() == 0) ? 4'd1 : 4'd0, 4'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
